// File: rtl/ddr_bw_pkg.sv
// rtl/ddr_bw_pkg.sv - shared types and chunk geometry for the DDR bandwidth-test sequencer
package ddr_bw_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PICK,
        ST_ISSUE,
        ST_WAIT_ACK,
        ST_WAIT_DONE,
        ST_DONE
    } state_e;

    localparam logic DIR_RD = 1'b0;
    localparam logic DIR_WR = 1'b1;

    function automatic logic [31:0] chunk_bytes(input int dw, input int beats, input int bursts);
        return 32'(bursts * beats * (dw / 8));
    endfunction

    function automatic logic [31:0] rlen_beats(input int beats, input int bursts);
        return 32'(bursts * beats);
    endfunction

    function automatic logic [31:0] wnb_bursts(input int bursts);
        return 32'(bursts);
    endfunction

endpackage

// File: rtl/ddr_bw_rr_pick.sv
// rtl/ddr_bw_rr_pick.sv - two-way round-robin grant between read and write directions
module ddr_bw_rr_pick
    import ddr_bw_pkg::*;
(
    input  logic aclk,
    input  logic areset,
    input  logic clr,
    input  logic en,
    input  logic rd_req,
    input  logic wr_req,
    output logic gnt_valid,
    output logic gnt_dir
);

    logic last_q;
    logic last_d;

    // last_q starts as WR so that the first contested grant goes to read
    always_comb begin
        gnt_valid = rd_req | wr_req;
        if (rd_req && wr_req) begin
            gnt_dir = ~last_q;
        end else if (rd_req) begin
            gnt_dir = DIR_RD;
        end else begin
            gnt_dir = DIR_WR;
        end

        last_d = last_q;
        if (clr) begin
            last_d = DIR_WR;
        end else if (en && gnt_valid) begin
            last_d = gnt_dir;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            last_q <= DIR_WR;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/ddr_bw_sched.sv
// rtl/ddr_bw_sched.sv - splits a bandwidth test into chunks and issues them to the AXI read/write engines
module ddr_bw_sched
    import ddr_bw_pkg::*;
#(
    parameter int DATA_WIDTH   = 64,
    parameter int BEATS        = 16,
    parameter int CHUNK_BURSTS = 16,
    parameter int ACK_TIMEOUT  = 16
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        cfg_start,
    input  logic [31:0] cfg_raddr,
    input  logic [31:0] cfg_waddr,
    input  logic [15:0] cfg_rnchunks,
    input  logic [15:0] cfg_wnchunks,
    input  logic        RIDLE_REG,
    input  logic        WIDLE_REG,
    output logic        RSTART_REG,
    output logic [31:0] RADDR_REG,
    output logic [31:0] RLENGTH_REG,
    output logic        WSTART_REG,
    output logic [31:0] WADDR_REG,
    output logic [31:0] WNBURST_REG,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] cycles,
    output logic [15:0] rd_cnt,
    output logic [15:0] wr_cnt
);

    localparam logic [31:0] CHUNK_BYTES = chunk_bytes(DATA_WIDTH, BEATS, CHUNK_BURSTS);
    localparam logic [31:0] RLEN        = rlen_beats(BEATS, CHUNK_BURSTS);
    localparam logic [31:0] WNB         = wnb_bursts(CHUNK_BURSTS);
    localparam int          TW          = $clog2(ACK_TIMEOUT + 1);

    state_e        state_q, state_d;
    logic          dir_q, dir_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [31:0]   rbase_q, rbase_d, wbase_q, wbase_d;
    logic [15:0]   rn_q, rn_d, wn_q, wn_d;
    logic [15:0]   rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
    logic [31:0]   cycles_q, cycles_d;
    logic          error_q, error_d;
    logic [31:0]   raddr_q, raddr_d, waddr_q, waddr_d;
    logic [31:0]   rlen_q, rlen_d, wnb_q, wnb_d;
    logic          rstart_q, rstart_d, wstart_q, wstart_d;

    logic accept;
    logic busy_s;
    logic idle_g;
    logic pick_en;
    logic gnt_valid;
    logic gnt_dir;

    assign busy_s = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign accept = cfg_start && !busy_s;
    assign idle_g = (dir_q == DIR_RD) ? RIDLE_REG : WIDLE_REG;

    // chunk index of a direction equals its completed count, since commands never overlap
    ddr_bw_rr_pick u_pick (
        .aclk      (aclk),
        .areset    (areset),
        .clr       (accept),
        .en        (pick_en),
        .rd_req    (rd_cnt_q != rn_q),
        .wr_req    (wr_cnt_q != wn_q),
        .gnt_valid (gnt_valid),
        .gnt_dir   (gnt_dir)
    );

    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        tmo_d    = tmo_q;
        rbase_d  = rbase_q;
        wbase_d  = wbase_q;
        rn_d     = rn_q;
        wn_d     = wn_q;
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        error_d  = error_q;
        raddr_d  = raddr_q;
        waddr_d  = waddr_q;
        rlen_d   = rlen_q;
        wnb_d    = wnb_q;
        rstart_d = 1'b0;
        wstart_d = 1'b0;
        pick_en  = 1'b0;
        cycles_d = (busy_s && cycles_q != 32'hFFFF_FFFF) ? cycles_q + 32'd1 : cycles_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    state_d  = ST_PICK;
                    rbase_d  = cfg_raddr;
                    wbase_d  = cfg_waddr;
                    rn_d     = cfg_rnchunks;
                    wn_d     = cfg_wnchunks;
                    rd_cnt_d = 16'd0;
                    wr_cnt_d = 16'd0;
                    error_d  = 1'b0;
                    cycles_d = 32'd0;
                    rlen_d   = RLEN;
                    wnb_d    = WNB;
                end
            end
            ST_PICK: begin
                pick_en = 1'b1;
                if (gnt_valid) begin
                    state_d = ST_ISSUE;
                    dir_d   = gnt_dir;
                    if (gnt_dir == DIR_RD) begin
                        raddr_d  = rbase_q + 32'(rd_cnt_q) * CHUNK_BYTES;
                        rstart_d = 1'b1;
                    end else begin
                        waddr_d  = wbase_q + 32'(wr_cnt_q) * CHUNK_BYTES;
                        wstart_d = 1'b1;
                    end
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT_ACK;
                tmo_d   = '0;
            end
            ST_WAIT_ACK: begin
                if (!idle_g) begin
                    state_d = ST_WAIT_DONE;
                end else if (tmo_q == TW'(ACK_TIMEOUT - 1)) begin
                    state_d = ST_DONE;
                    error_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (idle_g) begin
                    state_d = ST_PICK;
                    if (dir_q == DIR_RD) begin
                        rd_cnt_d = rd_cnt_q + 16'd1;
                    end else begin
                        wr_cnt_d = wr_cnt_q + 16'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q  <= ST_IDLE;
            dir_q    <= DIR_RD;
            tmo_q    <= '0;
            rbase_q  <= '0;
            wbase_q  <= '0;
            rn_q     <= '0;
            wn_q     <= '0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
            cycles_q <= '0;
            error_q  <= 1'b0;
            raddr_q  <= '0;
            waddr_q  <= '0;
            rlen_q   <= '0;
            wnb_q    <= '0;
            rstart_q <= 1'b0;
            wstart_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            tmo_q    <= tmo_d;
            rbase_q  <= rbase_d;
            wbase_q  <= wbase_d;
            rn_q     <= rn_d;
            wn_q     <= wn_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
            cycles_q <= cycles_d;
            error_q  <= error_d;
            raddr_q  <= raddr_d;
            waddr_q  <= waddr_d;
            rlen_q   <= rlen_d;
            wnb_q    <= wnb_d;
            rstart_q <= rstart_d;
            wstart_q <= wstart_d;
        end
    end

    assign RSTART_REG  = rstart_q;
    assign RADDR_REG   = raddr_q;
    assign RLENGTH_REG = rlen_q;
    assign WSTART_REG  = wstart_q;
    assign WADDR_REG   = waddr_q;
    assign WNBURST_REG = wnb_q;
    assign busy        = busy_s;
    assign done        = (state_q == ST_DONE);
    assign error       = error_q;
    assign cycles      = cycles_q;
    assign rd_cnt      = rd_cnt_q;
    assign wr_cnt      = wr_cnt_q;

endmodule

// File: doc/ddr_bw_sched.md
# ddr_bw_sched

Sequencer for the DDR bandwidth-test datapath. It splits one configured test into fixed-size chunks and issues them as read and write commands to the AXI master engines, alternating round-robin between the two directions. Each command is issued only after the previous one has completed. It sits between the register/control layer and the AXI master, driving the RSTART/RADDR/RLENGTH and WSTART/WADDR/WNBURST command ports, and reports busy/done/error status plus a cycle count for bandwidth computation.

## Interface
Parameters:
- DATA_WIDTH, 64, AXI data width in bits; sets chunk byte size.
- BEATS, 16, beats per AXI burst.
- CHUNK_BURSTS, 16, bursts per chunk command.
- ACK_TIMEOUT, 16, cycles allowed for an engine to drop idle after START.

Ports:
- aclk  in  1  clock.
- areset  in  1  asynchronous, active-high reset.
- cfg_start  in  1  single-cycle test start request.
- cfg_raddr  in  32  read base byte address.
- cfg_waddr  in  32  write base byte address.
- cfg_rnchunks  in  16  number of read chunks; 0 means no reads.
- cfg_wnchunks  in  16  number of write chunks; 0 means no writes.
- RIDLE_REG  in  1  read engine idle.
- WIDLE_REG  in  1  write engine idle.
- RSTART_REG  out  1  read command pulse.
- RADDR_REG  out  32  read chunk address.
- RLENGTH_REG  out  32  read length in beats.
- WSTART_REG  out  1  write command pulse.
- WADDR_REG  out  32  write chunk address.
- WNBURST_REG  out  32  write length in bursts.
- busy  out  1  test in progress.
- done  out  1  sticky test-complete flag.
- error  out  1  sticky ack-timeout flag.
- cycles  out  32  test duration in aclk cycles.
- rd_cnt  out  16  read chunks completed.
- wr_cnt  out  16  write chunks completed.

## Operation
- CHUNK_BYTES = CHUNK_BURSTS·BEATS·DATA_WIDTH/8; the defaults give 2048.
- RLENGTH_REG is CHUNK_BURSTS·BEATS (256). WNBURST_REG is CHUNK_BURSTS (16). Both are constant while busy.
- cfg_* is captured on an accepted cfg_start. cfg_start is accepted only in IDLE or DONE and is ignored while busy.
- Acceptance clears done, error, cycles, rd_cnt and wr_cnt.
- FSM states: IDLE → PICK → ISSUE → WAIT_ACK → WAIT_DONE → PICK … → DONE.
  - PICK: if both directions have chunks remaining, grant the direction not granted last; the first grant is read. Otherwise grant whichever direction has chunks remaining. If neither does, go to DONE.
  - ISSUE: pulse the granted START for one cycle. Address = base + n·CHUNK_BYTES, where n is that direction's chunk index; addition is modulo 2^32.
  - WAIT_ACK: wait for the granted idle input to go low. If it is still high after ACK_TIMEOUT cycles, set error and go to DONE.
  - WAIT_DONE: wait for the granted idle input to return high. Then increment rd_cnt or wr_cnt and go to PICK.
  - DONE: done=1, busy=0. Hold until the next accepted cfg_start.
- cycles increments every cycle while busy and saturates at 0xFFFFFFFF.
- rnchunks=wnchunks=0: the test passes through PICK and reaches DONE; counts stay 0.
- Reset mid-test: all outputs go to reset values immediately, FSM goes to IDLE, and no further START is issued.

## Timing
- Reset values: every output is 0.
- cfg_start sampled in cycle 0 → busy=1 in cycle 1, PICK in cycle 1, first START high in cycle 2.
- START is high for exactly one cycle. Address and length outputs are registered and valid from the START cycle until the next ISSUE.
- Idle returning high in cycle k → counter increment and PICK in k+1 → next START in k+2.
- Zero-chunk test: done=1 in cycle 2.
- done and busy are never both 1.
- Idle edges are considered only in WAIT_ACK and WAIT_DONE, and only for the granted direction.

## Structure
- Package ddr_bw_pkg holds:
  - the FSM state enum;
  - CHUNK_BYTES / RLEN / WNB derivation functions;
  - the direction encoding (DIR_RD=0, DIR_WR=1).
- One natural sub-module: ddr_bw_rr_pick. It holds the last-grant register and produces the grant from the two remaining-count-nonzero flags.
- Address and chunk counters stay in the top level.

## Test plan
- Read-only: raddr=0x1000_0000, rnchunks=3, wnchunks=0; engine model acks in 2 cycles and completes in 40 cycles.
  - Required: RADDR 0x1000_0000, 0x1000_0800, 0x1000_1000; RLENGTH=256.
  - Required: rd_cnt=3, done=1, no WSTART.
- Interleave: rnchunks=2, wnchunks=2.
  - Required: START order R,W,R,W; WNBURST=16.
  - Required: rd_cnt=wr_cnt=2; cycles equals the busy duration.
- Unequal: rnchunks=1, wnchunks=3.
  - Required: order R,W,W,W; WADDR steps by 0x800.
- Wrap: raddr=0xFFFF_F800, rnchunks=2.
  - Required: second RADDR=0x0000_0000.
- Timeout: RIDLE_REG held high.
  - Required: error=1 and done=1 exactly ACK_TIMEOUT cycles after WAIT_ACK entry; rd_cnt=0.
- Zero chunks, then reset mid-test.
  - Zero chunks: done in cycle 2 with counts 0.
  - Reset asserted during WAIT_DONE: all outputs 0 asynchronously, and no START follows release.
  - A cfg_start during busy is ignored.
